// File: rtl/reg_transfer_sequencer_if.sv
// Instruction handshake and register-file bus between the sequencer and
// its neighbours.
//
// Handshake: an instruction transfers on a rising clock edge where
// instr_valid and instr_ready are both high. The source holds instr_op,
// instr_rd, instr_rs and instr_imm stable while instr_valid is high and
// may only drop instr_valid after the transfer edge. The sequencer raises
// instr_ready only while idle and never depends on instr_valid to do so.
interface reg_transfer_sequencer_if #(
  parameter int WIDTH = 16
);
  logic             instr_valid;
  logic             instr_ready;
  logic [1:0]       instr_op;
  logic [1:0]       instr_rd;
  logic [1:0]       instr_rs;
  logic [WIDTH-1:0] instr_imm;
  logic [WIDTH-1:0] bus_in;
  logic [WIDTH-1:0] bus_out;
  logic [3:0]       reg_enable_read;
  logic [3:0]       reg_enable_out;

  // Environment side: issues instructions and models the register file.
  modport master (
    output instr_valid, instr_op, instr_rd, instr_rs, instr_imm, bus_in,
    input  instr_ready, bus_out, reg_enable_read, reg_enable_out
  );

  // Sequencer side.
  modport slave (
    input  instr_valid, instr_op, instr_rd, instr_rs, instr_imm, bus_in,
    output instr_ready, bus_out, reg_enable_read, reg_enable_out
  );
endinterface

// File: rtl/reg_transfer_sequencer.sv
// Multi-cycle sequencer in front of a four-entry register file. Accepts
// MOV / LDI / ADD / SUB, reads operands over the register file's
// registered output bus (two cycles per read), then writes the result
// back in a single WB cycle. Keeps zero/carry flags for ADD/SUB.
module reg_transfer_sequencer #(
  parameter int WIDTH = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  reg_transfer_sequencer_if.slave bus,
  output logic                  busy,
  output logic                  done,
  output logic                  flag_zero,
  output logic                  flag_carry,
  output logic [2:0]            dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RDA1 = 3'd1,
    S_RDA2 = 3'd2,
    S_RDB1 = 3'd3,
    S_RDB2 = 3'd4,
    S_WB   = 3'd5
  } state_t;

  localparam logic [1:0] OP_MOV = 2'b00;
  localparam logic [1:0] OP_LDI = 2'b01;
  localparam logic [1:0] OP_ADD = 2'b10;
  localparam logic [1:0] OP_SUB = 2'b11;

  state_t           state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [1:0]       rd_q, rd_d;
  logic [1:0]       rs_q, rs_d;
  logic [WIDTH-1:0] imm_q, imm_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic             flag_zero_q, flag_zero_d;
  logic             flag_carry_q, flag_carry_d;

  logic [WIDTH:0]   sum_ext;
  logic [WIDTH:0]   diff_ext;
  logic [WIDTH-1:0] result;
  logic             result_carry;

  function automatic logic [3:0] onehot(input logic [1:0] idx);
    logic [3:0] v;
    v = 4'b0000;
    v[idx] = 1'b1;
    return v;
  endfunction

  // Result and carry/borrow from the latched operands; the extra top bit of
  // the widened subtraction is the borrow (set exactly when opA < opB).
  always_comb begin
    sum_ext      = {1'b0, opa_q} + {1'b0, opb_q};
    diff_ext     = {1'b0, opa_q} - {1'b0, opb_q};
    result       = '0;
    result_carry = 1'b0;
    case (op_q)
      OP_LDI: result = imm_q;
      OP_MOV: result = opb_q;
      OP_ADD: begin
        result       = sum_ext[WIDTH-1:0];
        result_carry = sum_ext[WIDTH];
      end
      OP_SUB: begin
        result       = diff_ext[WIDTH-1:0];
        result_carry = diff_ext[WIDTH];
      end
      default: result = '0;
    endcase
  end

  // Next-state, instruction latch, operand capture and flag update.
  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    rd_d         = rd_q;
    rs_d         = rs_q;
    imm_d        = imm_q;
    opa_d        = opa_q;
    opb_d        = opb_q;
    flag_zero_d  = flag_zero_q;
    flag_carry_d = flag_carry_q;
    case (state_q)
      S_IDLE: begin
        if (bus.instr_valid) begin
          op_d  = bus.instr_op;
          rd_d  = bus.instr_rd;
          rs_d  = bus.instr_rs;
          imm_d = bus.instr_imm;
          case (bus.instr_op)
            OP_LDI:  state_d = S_WB;
            OP_MOV:  state_d = S_RDB1;
            default: state_d = S_RDA1;
          endcase
        end
      end
      S_RDA1: state_d = S_RDA2;
      S_RDA2: begin
        opa_d   = bus.bus_in;
        state_d = S_RDB1;
      end
      S_RDB1: state_d = S_RDB2;
      S_RDB2: begin
        opb_d   = bus.bus_in;
        state_d = S_WB;
      end
      S_WB: begin
        // op[1] marks the arithmetic ops; MOV/LDI keep the old flags.
        if (op_q[1]) begin
          flag_zero_d  = (result == '0);
          flag_carry_d = result_carry;
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      op_q         <= '0;
      rd_q         <= '0;
      rs_q         <= '0;
      imm_q        <= '0;
      opa_q        <= '0;
      opb_q        <= '0;
      flag_zero_q  <= 1'b0;
      flag_carry_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      rd_q         <= rd_d;
      rs_q         <= rs_d;
      imm_q        <= imm_d;
      opa_q        <= opa_d;
      opb_q        <= opb_d;
      flag_zero_q  <= flag_zero_d;
      flag_carry_q <= flag_carry_d;
    end
  end

  // Register-file enables and write data, decoded from state and latched
  // indices only so at most one output enable is ever set.
  always_comb begin
    bus.reg_enable_out  = 4'b0000;
    bus.reg_enable_read = 4'b0000;
    bus.bus_out         = '0;
    case (state_q)
      S_RDA1, S_RDA2: bus.reg_enable_out = onehot(rd_q);
      S_RDB1, S_RDB2: bus.reg_enable_out = onehot(rs_q);
      S_WB: begin
        bus.reg_enable_read = onehot(rd_q);
        bus.bus_out         = result;
      end
      default: bus.reg_enable_out = 4'b0000;
    endcase
  end

  assign bus.instr_ready = (state_q == S_IDLE);
  assign busy            = (state_q != S_IDLE);
  assign done            = (state_q == S_WB);
  assign flag_zero       = flag_zero_q;
  assign flag_carry      = flag_carry_q;
  assign dbg_state       = state_q;

endmodule
